// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
// Optional feature macro: FIFO_WRARB_PACKET_LOCK_EN (used by fifo_write_arbiter).
package fifo_arb_pkg;

  // Arbiter states: no grant held, or one requester owns the write port.
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Largest number of requesters the arbiter is built to support.
  localparam int MAX_REQ = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: rotate the request vector so that rr_ptr sits
// at bit 0, pick the lowest set bit, then rotate the index back.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any
);

  localparam int LANES    = (NUM_REQ > MAX_REQ) ? MAX_REQ : NUM_REQ;
  localparam int SUM_BITS = ID_WIDTH + 1;

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [ID_WIDTH-1:0]  offset;
  logic [SUM_BITS-1:0]  unrotated;

  // Rotate, priority-encode from the pointer upward, and map back to a requester index.
  always_comb begin
    doubled   = {req, req} >> rr_ptr;
    rotated   = doubled[NUM_REQ-1:0];
    offset    = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = ID_WIDTH'(i);
      end
    end
    unrotated = {1'b0, offset} + {1'b0, rr_ptr};
    if (unrotated >= SUM_BITS'(NUM_REQ)) begin
      unrotated = unrotated - SUM_BITS'(NUM_REQ);
    end
    winner = unrotated[ID_WIDTH-1:0];
    any    = |req;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the write port of the clock-crossing FIFO.
// Optional feature macro: FIFO_WRARB_PACKET_LOCK_EN
//   defined   -> a grant is held until the word flagged req_last is accepted
//   undefined -> a grant is released after every accepted word
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          reset,
  input  logic                          write_clk,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  input  logic                          fifo_can_write,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id
);

  arb_state_e          state_q;
  logic [ID_WIDTH-1:0] rr_ptr_q;
  logic [ID_WIDTH-1:0] rr_ptr_d;
  logic [ID_WIDTH-1:0] grant_id_q;
  logic                grant_valid_q;

  logic [ID_WIDTH-1:0]   winner;
  logic                  anyReq;
  logic                  reqSel;
  logic [DATA_WIDTH-1:0] dataSel;
  logic                  releaseGrant;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .any    (anyReq)
  );

  // Pull out the request bit and data word belonging to the current grant holder.
  always_comb begin
    reqSel  = 1'b0;
    dataSel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_WIDTH'(i)) begin
        reqSel  = req[i];
        dataSel = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Forward the holder's word only while the FIFO can take it; ack mirrors the write.
  always_comb begin
    fifo_write      = grant_valid_q & reqSel & fifo_can_write;
    fifo_write_data = grant_valid_q ? dataSel : '0;
    req_ack         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_WIDTH'(i)) begin
        req_ack[i] = fifo_write;
      end
    end
  end

`ifdef FIFO_WRARB_PACKET_LOCK_EN
  logic lastSel;

  // Packet mode: the grant ends only on the accepted final word of a packet.
  always_comb begin
    lastSel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_WIDTH'(i)) begin
        lastSel = req_last[i];
      end
    end
    releaseGrant = fifo_write & lastSel;
  end
`else
  logic unusedLast;
  assign unusedLast = ^req_last;

  // Word mode: every accepted word ends the grant so arbitration is per word.
  always_comb begin
    releaseGrant = fifo_write;
  end
`endif

  // Next search start is the requester just after the one being released.
  always_comb begin
    if (grant_id_q == ID_WIDTH'(NUM_REQ - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = grant_id_q + ID_WIDTH'(1);
    end
  end

  // Grant FSM: pick a winner when idle, hold the port until the release condition.
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (anyReq) begin
            grant_id_q    <= winner;
            grant_valid_q <= 1'b1;
            state_q       <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (releaseGrant) begin
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= ARB_IDLE;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=16).
// Expected sequences differ with FIFO_WRARB_PACKET_LOCK_EN; both are spelled out.
module tb_fifo_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int IDW  = 2;

  logic                 reset;
  logic                 write_clk;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ack;
  logic                 fifo_write;
  logic [DW-1:0]        fifo_write_data;
  logic                 fifo_can_write;
  logic                 grant_valid;
  logic [IDW-1:0]       grant_id;

  int compared   = 0;
  int mismatched = 0;
  int sent [NREQ];
  int len  [NREQ];
  bit lastEvery;

  fifo_write_arbiter #(
    .NUM_REQ    (NREQ),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IDW)
  ) dut (
    .reset           (reset),
    .write_clk       (write_clk),
    .req             (req),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ack         (req_ack),
    .fifo_write      (fifo_write),
    .fifo_write_data (fifo_write_data),
    .fifo_can_write  (fifo_can_write),
    .grant_valid     (grant_valid),
    .grant_id        (grant_id)
  );

  // Free-running write clock, 10 time units per cycle.
  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Each requester offers word number sent[i] of a len[i]-word packet.
  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      if (sent[i] < len[i]) begin
        req[i]                 = 1'b1;
        req_data[i*DW +: DW]   = 16'hA000 | 16'(i * 16) | 16'(sent[i]);
        req_last[i]            = lastEvery || (sent[i] == len[i] - 1);
      end else begin
        req[i]                 = 1'b0;
        req_data[i*DW +: DW]   = '0;
        req_last[i]            = 1'b0;
      end
    end
  endtask

  task automatic setLoad(input int l0, input int l1, input int l2, input int l3,
                         input bit everyLast);
    len[0] = l0; len[1] = l1; len[2] = l2; len[3] = l3;
    for (int i = 0; i < NREQ; i++) sent[i] = 0;
    lastEvery = everyLast;
  endtask

  // One clock: drive, check at the falling edge, then advance past the rising edge.
  task automatic runCycle(input string tag, input logic expGv, input logic [1:0] expGid,
                          input logic [15:0] expData, input logic can);
    logic            expWr;
    logic [NREQ-1:0] ackSeen;
    expWr          = (expData != 16'h0000);
    fifo_can_write = can;
    applyStimulus();
    @(negedge write_clk);
    checkOutput($sformatf("%s grant_valid", tag), 32'(grant_valid), 32'(expGv));
    if (expGv) checkOutput($sformatf("%s grant_id", tag), 32'(grant_id), 32'(expGid));
    checkOutput($sformatf("%s fifo_write", tag), 32'(fifo_write), 32'(expWr));
    if (expWr) begin
      checkOutput($sformatf("%s write_data", tag), 32'(fifo_write_data), 32'(expData));
    end else if (!expGv) begin
      checkOutput($sformatf("%s idle_data", tag), 32'(fifo_write_data), 32'h0);
    end
    checkOutput($sformatf("%s req_ack", tag), 32'(req_ack),
                expWr ? (32'h1 << expGid) : 32'h0);
    ackSeen = req_ack;
    @(posedge write_clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (ackSeen[i]) sent[i]++;
  endtask

  initial begin
    reset          = 1'b1;
    req            = '0;
    req_data       = '0;
    req_last       = '0;
    fifo_can_write = 1'b1;
    setLoad(0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge write_clk);
    #1;
    checkOutput("rst grant_valid", 32'(grant_valid), 32'h0);
    checkOutput("rst grant_id", 32'(grant_id), 32'h0);
    checkOutput("rst fifo_write", 32'(fifo_write), 32'h0);
    checkOutput("rst req_ack", 32'(req_ack), 32'h0);
    reset = 1'b0;

    $display("[TB] idle with no requests");
    for (int c = 0; c < 10; c++) runCycle($sformatf("t1c%0d", c), 1'b0, 2'd0, 16'h0, 1'b1);

    $display("[TB] all four requesters send two-word packets");
    setLoad(2, 2, 2, 2, 1'b0);
`ifdef FIFO_WRARB_PACKET_LOCK_EN
    runCycle("t2c0",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t2c1",  1'b1, 2'd0, 16'hA000, 1'b1);
    runCycle("t2c2",  1'b1, 2'd0, 16'hA001, 1'b1);
    runCycle("t2c3",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t2c4",  1'b1, 2'd1, 16'hA010, 1'b1);
    runCycle("t2c5",  1'b1, 2'd1, 16'hA011, 1'b1);
    runCycle("t2c6",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t2c7",  1'b1, 2'd2, 16'hA020, 1'b1);
    runCycle("t2c8",  1'b1, 2'd2, 16'hA021, 1'b1);
    runCycle("t2c9",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t2c10", 1'b1, 2'd3, 16'hA030, 1'b1);
    runCycle("t2c11", 1'b1, 2'd3, 16'hA031, 1'b1);
    runCycle("t2c12", 1'b0, 2'd0, 16'h0,    1'b1);
`else
    runCycle("t2c0",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t2c1",  1'b1, 2'd0, 16'hA000, 1'b1);
    runCycle("t2c2",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t2c3",  1'b1, 2'd1, 16'hA010, 1'b1);
    runCycle("t2c4",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t2c5",  1'b1, 2'd2, 16'hA020, 1'b1);
    runCycle("t2c6",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t2c7",  1'b1, 2'd3, 16'hA030, 1'b1);
    runCycle("t2c8",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t2c9",  1'b1, 2'd0, 16'hA001, 1'b1);
    runCycle("t2c10", 1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t2c11", 1'b1, 2'd1, 16'hA011, 1'b1);
    runCycle("t2c12", 1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t2c13", 1'b1, 2'd2, 16'hA021, 1'b1);
    runCycle("t2c14", 1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t2c15", 1'b1, 2'd3, 16'hA031, 1'b1);
    runCycle("t2c16", 1'b0, 2'd0, 16'h0,    1'b1);
`endif

    $display("[TB] requester 2 stalled by a full FIFO for 5 cycles");
    setLoad(0, 0, 3, 0, 1'b0);
`ifdef FIFO_WRARB_PACKET_LOCK_EN
    runCycle("t3c0", 1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t3c1", 1'b1, 2'd2, 16'hA020, 1'b1);
    for (int c = 2; c < 7; c++) runCycle($sformatf("t3c%0d", c), 1'b1, 2'd2, 16'h0, 1'b0);
    runCycle("t3c7", 1'b1, 2'd2, 16'hA021, 1'b1);
    runCycle("t3c8", 1'b1, 2'd2, 16'hA022, 1'b1);
    runCycle("t3c9", 1'b0, 2'd0, 16'h0,    1'b1);
`else
    runCycle("t3c0", 1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t3c1", 1'b1, 2'd2, 16'hA020, 1'b1);
    runCycle("t3c2", 1'b0, 2'd0, 16'h0,    1'b0);
    for (int c = 3; c < 7; c++) runCycle($sformatf("t3c%0d", c), 1'b1, 2'd2, 16'h0, 1'b0);
    runCycle("t3c7", 1'b1, 2'd2, 16'hA021, 1'b1);
    runCycle("t3c8", 1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t3c9", 1'b1, 2'd2, 16'hA022, 1'b1);
    runCycle("t3c10", 1'b0, 2'd0, 16'h0,   1'b1);
`endif

    $display("[TB] requesters 1 and 3 alternate word by word");
    setLoad(0, 3, 0, 3, 1'b1);
    runCycle("t4c0",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t4c1",  1'b1, 2'd3, 16'hA030, 1'b1);
    runCycle("t4c2",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t4c3",  1'b1, 2'd1, 16'hA010, 1'b1);
    runCycle("t4c4",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t4c5",  1'b1, 2'd3, 16'hA031, 1'b1);
    runCycle("t4c6",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t4c7",  1'b1, 2'd1, 16'hA011, 1'b1);
    runCycle("t4c8",  1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t4c9",  1'b1, 2'd3, 16'hA032, 1'b1);
    runCycle("t4c10", 1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t4c11", 1'b1, 2'd1, 16'hA012, 1'b1);
    runCycle("t4c12", 1'b0, 2'd0, 16'h0,    1'b1);

    $display("[TB] reset in the middle of requester 1's packet");
    setLoad(0, 3, 0, 0, 1'b0);
    runCycle("t5c0", 1'b0, 2'd0, 16'h0, 1'b1);
    fifo_can_write = 1'b1;
    applyStimulus();
    #1;
    checkOutput("t5 pre grant_valid", 32'(grant_valid), 32'h1);
    checkOutput("t5 pre grant_id", 32'(grant_id), 32'h1);
    checkOutput("t5 pre fifo_write", 32'(fifo_write), 32'h1);
    checkOutput("t5 pre write_data", 32'(fifo_write_data), 32'hA010);
    checkOutput("t5 pre req_ack", 32'(req_ack), 32'h2);
    reset = 1'b1;
    #1;
    checkOutput("t5 rst grant_valid", 32'(grant_valid), 32'h0);
    checkOutput("t5 rst grant_id", 32'(grant_id), 32'h0);
    checkOutput("t5 rst fifo_write", 32'(fifo_write), 32'h0);
    checkOutput("t5 rst write_data", 32'(fifo_write_data), 32'h0);
    checkOutput("t5 rst req_ack", 32'(req_ack), 32'h0);
    @(posedge write_clk);
    #1;
    reset = 1'b0;
    setLoad(1, 1, 0, 0, 1'b1);
    runCycle("t5c1", 1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t5c2", 1'b1, 2'd0, 16'hA000, 1'b1);
    runCycle("t5c3", 1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t5c4", 1'b1, 2'd1, 16'hA010, 1'b1);
    runCycle("t5c5", 1'b0, 2'd0, 16'h0,    1'b1);

    $display("[TB] lone requester 3 re-granted across pointer wrap");
    setLoad(0, 0, 0, 2, 1'b1);
    runCycle("t6c0", 1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t6c1", 1'b1, 2'd3, 16'hA030, 1'b1);
    runCycle("t6c2", 1'b0, 2'd0, 16'h0,    1'b1);
    runCycle("t6c3", 1'b1, 2'd3, 16'hA031, 1'b1);
    runCycle("t6c4", 1'b0, 2'd0, 16'h0,    1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
